// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accelerator program sequencer.
package acc_cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam int unsigned INSTR_W = 8;
    localparam int unsigned LEN_W   = 5;
    localparam int unsigned OPC_MSB = 7;
    localparam int unsigned OPC_LSB = 4;

    localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

    // Opcode nibble of an instruction byte.
    function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] b);
        return b[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/acc_valid_delay.sv
// Delay line: valid_out follows valid_in by RES_LAT clock cycles.
module acc_valid_delay #(
    parameter int unsigned RES_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_in,
    output logic valid_out
);

    logic [RES_LAT-1:0] sr;

    // Shift register of pending captures, flushed by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr <= '0;
        end else begin
            sr[0] <= valid_in;
            for (int i = 1; i < int'(RES_LAT); i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    assign valid_out = sr[RES_LAT-1];

endmodule

// File: rtl/acc_prog_sequencer.sv
// Program buffer that replays stored instruction bytes to the CPU and
// captures the CPU results a fixed latency later.
module acc_prog_sequencer
    import acc_cpu_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned RES_LAT = 1,
    parameter logic [3:0]  HALT_OP = HALT_OP_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    input  logic       start,
    output logic [7:0] instr_out,
    output logic       instr_valid,
    input  logic [7:0] result_in,
    output logic [7:0] result_out,
    output logic       result_valid,
    output logic [7:0] signature,
    output logic [4:0] prog_len,
    output logic       busy,
    output logic       done
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LW = LEN_W;
    localparam int unsigned DW = INSTR_W;
    localparam int unsigned CW = 2;

    seq_state_t        state, state_n;
    logic [DW-1:0]     mem [DEPTH];
    logic [AW-1:0]     rd_ptr, rd_ptr_n, rd_inc_c;
    logic [LW-1:0]     prog_len_n;
    logic [DW-1:0]     instr_out_n, result_out_n, signature_n;
    logic              instr_valid_n, result_valid_n;
    logic              load_ready_n, busy_n, done_n;
    logic [CW-1:0]     drain_cnt, drain_cnt_n;
    logic              wr_en_c, last_c, cap_dly;

    assign rd_inc_c = rd_ptr + AW'(1);
    assign last_c   = (LW'(rd_ptr) == LW'(prog_len - LW'(1))) ||
                      (opcode_of(instr_out) == HALT_OP);

    // Issue-to-capture timing, fed one cycle early by the next-state valid.
    acc_valid_delay #(.RES_LAT(RES_LAT)) u_valid_delay (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (instr_valid_n),
        .valid_out (cap_dly)
    );

    // Program buffer storage; contents survive reset and clear.
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem[prog_len[AW-1:0]] <= load_data;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            rd_ptr       <= '0;
            prog_len     <= '0;
            drain_cnt    <= '0;
            instr_out    <= '0;
            instr_valid  <= 1'b0;
            result_out   <= '0;
            result_valid <= 1'b0;
            signature    <= '0;
            load_ready   <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_n;
            rd_ptr       <= rd_ptr_n;
            prog_len     <= prog_len_n;
            drain_cnt    <= drain_cnt_n;
            instr_out    <= instr_out_n;
            instr_valid  <= instr_valid_n;
            result_out   <= result_out_n;
            result_valid <= result_valid_n;
            signature    <= signature_n;
            load_ready   <= load_ready_n;
            busy         <= busy_n;
            done         <= done_n;
        end
    end

    // Next-state, buffer control and next output values.
    always_comb begin
        state_n        = state;
        rd_ptr_n       = rd_ptr;
        prog_len_n     = prog_len;
        drain_cnt_n    = drain_cnt;
        instr_out_n    = '0;
        instr_valid_n  = 1'b0;
        wr_en_c        = 1'b0;
        result_valid_n = cap_dly;
        result_out_n   = result_out;
        signature_n    = signature;

        if (cap_dly) begin
            result_out_n = result_in;
            signature_n  = signature ^ result_in;
        end

        case (state)
            ST_IDLE: begin
                if (clear) begin
                    prog_len_n = '0;
                end else if (start && (prog_len != '0)) begin
                    state_n       = ST_RUN;
                    rd_ptr_n      = '0;
                    instr_out_n   = mem[0];
                    instr_valid_n = 1'b1;
                    signature_n   = '0;
                end else if (load_valid && load_ready) begin
                    wr_en_c    = 1'b1;
                    prog_len_n = prog_len + LW'(1);
                end
            end
            ST_RUN: begin
                if (last_c) begin
                    state_n     = ST_DRAIN;
                    drain_cnt_n = CW'(RES_LAT - 1);
                end else begin
                    rd_ptr_n      = rd_inc_c;
                    instr_out_n   = mem[rd_inc_c];
                    instr_valid_n = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    state_n = ST_DONE;
                end else begin
                    drain_cnt_n = drain_cnt - CW'(1);
                end
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        busy_n       = (state_n == ST_RUN) || (state_n == ST_DRAIN);
        done_n       = (state_n == ST_DONE);
        load_ready_n = (state_n == ST_IDLE) && (prog_len_n < LW'(DEPTH));
    end

endmodule
